alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter ALU_ID, default 0: index of the reservation-station slot served, driven onto result_src_out.
REQ-002 Parameter SHIFT_ITER, default 1: 1 = iterative shifter (1 bit/cycle); 0 = single-cycle barrel shift.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global ready; when 0, all state holds.
REQ-006 flush  input  1  misprediction flush; abandons current instruction.
REQ-007 busy_in  input  1  RS slot holds a valid instruction.
REQ-008 pc_in  input  `addr_t (32)  instruction PC.
REQ-009 op_in  input  `sinst_t  decoded ALU opcode.
REQ-010 tagx_in, tagy_in  input  `regtag_t  operand tags; `UNLOCKED = operand ready.
REQ-011 tagw_in  input  `regtag_t  destination rename tag.
REQ-012 datax_in, datay_in  input  `word_t (32)  operand values; datay carries immediate for I/U-type.
REQ-013 target_in  input  `regaddr_t (5)  destination architectural register.
REQ-014 cdb_grant  input  1  common-data-bus arbiter grant for this unit.
REQ-015 busy_out  output  1  unit occupied; fed to RS as busy_alu.
REQ-016 en_out  output  1  result valid, requesting CDB; fed to RS as en_alu.
REQ-017 data_out  output  `word_t  result; fed to RS as alu_data.
REQ-018 tag_out  output  `regtag_t  broadcast tag (captured tagw).
REQ-019 target_out  output  `regaddr_t  destination register.
REQ-020 result_src_out  output  1  constant ALU_ID.

Function
REQ-021 FSM states IDLE, EXEC, SHIFT, DONE; all transitions gated by rdy.
REQ-022 IDLE->EXEC when busy_in=1 and tagx_in=tagy_in=`UNLOCKED; capture pc, op, datax, datay, tagw, target that cycle.
REQ-023 Capture requires no operand forwarding; RS owns operand wake-up.
REQ-024 EXEC: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, LUI (datay), AUIPC (pc+datay) compute in one cycle, ->DONE.
REQ-025 EXEC with SLL/SRL/SRA: shamt=datay[4:0]; SHIFT_ITER=0 or shamt=0 -> compute, ->DONE; else ->SHIFT with counter=shamt.
REQ-026 SHIFT: shift working register 1 bit/cycle (SRA replicates bit 31), decrement counter; counter reaching 0 ->DONE; shamt N takes N cycles in SHIFT.
REQ-027 Arithmetic modulo 2^32; SLT/SLTU results 0 or 1 zero-extended; unknown op yields 0.
REQ-028 DONE: en_out=1, data/tag/target stable until cdb_grant; grant ->IDLE next cycle.
REQ-029 cdb_grant outside DONE is ignored.
REQ-030 busy_out=1 in EXEC, SHIFT, DONE; 0 in IDLE, including the cycle after grant.
REQ-031 Minimum latency capture->en_out: 2 cycles (capture, EXEC); grant in first DONE cycle frees unit 3 cycles after capture.
REQ-032 New instruction not accepted in the cycle grant is taken; earliest capture is the following IDLE cycle.
REQ-033 flush in any state -> IDLE next cycle, en_out=0, busy_out=0; flush overrides simultaneous grant and capture.
REQ-034 rdy=0 freezes state, counter and outputs, including a pending DONE.

Reset
REQ-035 rst (synchronous, active-high, priority over rdy and flush) -> IDLE; busy_out=0, en_out=0, data_out=0, target_out=0, counter=0, tag_out=`UNLOCKED.
REQ-036 Reset mid-SHIFT or mid-DONE discards the instruction without broadcast.

Structure
REQ-037 `addr_t, `word_t, `sinst_t, `regtag_t, `regaddr_t, `UNLOCKED and ALU opcode encodings belong in the shared definitions header.
REQ-038 One sub-module alu_core: combinational op/operand -> result, reused by EXEC; shifter iteration stays in alu_exec.

Verification
REQ-039 ADD datax=7, datay=0xFFFFFFFE, tags unlocked, tagw=3, grant immediate -> en_out 2 cycles after capture, data_out=5, tag_out=3, busy_out falls next cycle.
REQ-040 busy_in=1, tagy_in=4 (locked) for 5 cycles then `UNLOCKED -> no capture until tag unlocked; then SLT -1<1 -> data_out=1.
REQ-041 SRA datax=0x80000000, datay=4, SHIFT_ITER=1 -> 4 SHIFT cycles, data_out=0xF8000000; shamt=0 -> DONE after EXEC.
REQ-042 DONE with cdb_grant withheld 6 cycles -> en_out and data_out stable 6 cycles, busy_out=1 throughout.
REQ-043 flush during SHIFT and during DONE with grant=1 -> IDLE next cycle, en_out never seen with grant; rst same cycle -> all REQ-035 values.
REQ-044 rdy=0 for 3 cycles mid-SHIFT -> counter frozen, final result and total latency +3.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared ALU execution-unit types, opcode encodings and the one-bit shift step.
// Imported by the interface, the combinational core and the FSM wrapper.
package alu_exec_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  sinst_t;
  typedef logic [3:0]  regtag_t;
  typedef logic [4:0]  regaddr_t;

  localparam regtag_t UNLOCKED = 4'hF;

  localparam sinst_t OP_ADD   = 4'd0;
  localparam sinst_t OP_SUB   = 4'd1;
  localparam sinst_t OP_AND   = 4'd2;
  localparam sinst_t OP_OR    = 4'd3;
  localparam sinst_t OP_XOR   = 4'd4;
  localparam sinst_t OP_SLT   = 4'd5;
  localparam sinst_t OP_SLTU  = 4'd6;
  localparam sinst_t OP_LUI   = 4'd7;
  localparam sinst_t OP_AUIPC = 4'd8;
  localparam sinst_t OP_SLL   = 4'd9;
  localparam sinst_t OP_SRL   = 4'd10;
  localparam sinst_t OP_SRA   = 4'd11;

  function automatic logic is_shift(input sinst_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // One iteration of the serial shifter; SRA keeps replicating the sign bit.
  function automatic word_t shift_step(input sinst_t op, input word_t v);
    case (op)
      OP_SLL:  return {v[30:0], 1'b0};
      OP_SRA:  return {v[31], v[31:1]};
      default: return {1'b0, v[31:1]};
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Issue/result bundle between a reservation-station slot (master) and the ALU unit (slave).
// The slot drives operands and the CDB grant; the unit drives occupancy and the broadcast result.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic     busy_in;
  addr_t    pc_in;
  sinst_t   op_in;
  regtag_t  tagx_in;
  regtag_t  tagy_in;
  regtag_t  tagw_in;
  word_t    datax_in;
  word_t    datay_in;
  regaddr_t target_in;
  logic     cdb_grant;

  logic     busy_out;
  logic     en_out;
  word_t    data_out;
  regtag_t  tag_out;
  regaddr_t target_out;
  logic     result_src_out;

  modport master (
    output busy_in, pc_in, op_in, tagx_in, tagy_in, tagw_in, datax_in, datay_in, target_in, cdb_grant,
    input  busy_out, en_out, data_out, tag_out, target_out, result_src_out
  );

  modport slave (
    input  busy_in, pc_in, op_in, tagx_in, tagy_in, tagw_in, datax_in, datay_in, target_in, cdb_grant,
    output busy_out, en_out, data_out, tag_out, target_out, result_src_out
  );

endinterface

// File: rtl/alu_exec_core.sv
// Combinational ALU datapath: opcode + operands -> 32-bit result, shifts done as a barrel shift.
// Zero latency, no flow control; unknown opcodes produce zero.
module alu_core
  import alu_exec_pkg::*;
(
  input  sinst_t op,
  input  word_t  a,
  input  word_t  b,
  input  addr_t  pc,
  output word_t  result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SLT:   result = {31'b0, ($signed(a) < $signed(b))};
      OP_SLTU:  result = {31'b0, (a < b)};
      OP_LUI:   result = b;
      OP_AUIPC: result = pc + b;
      OP_SLL:   result = a << shamt;
      OP_SRL:   result = a >> shamt;
      OP_SRA:   result = word_t'($signed(a) >>> shamt);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: capture ready operands, execute (1 cycle, or 1 + shamt with the serial shifter),
// then hold the result on the CDB until granted; rdy=0 freezes everything, flush abandons the instruction.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int ALU_ID     = 0,
  parameter int SHIFT_ITER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  alu_exec_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  addr_t      pc_q;
  sinst_t     op_q;
  word_t      x_q;
  word_t      y_q;
  word_t      res_q;
  regtag_t    tag_q;
  regaddr_t   tgt_q;
  logic [4:0] cnt_q;
  word_t      core_res;
  logic       capture;
  logic       go_serial;

  alu_core u_core (
    .op     (op_q),
    .a      (x_q),
    .b      (y_q),
    .pc     (pc_q),
    .result (core_res)
  );

  assign capture   = bus.busy_in && (bus.tagx_in == UNLOCKED) && (bus.tagy_in == UNLOCKED);
  assign go_serial = (SHIFT_ITER != 0) && is_shift(op_q) && (y_q[4:0] != 5'd0);

  // rdy gates every transition, flush included, so a stalled pipeline sees no state change at all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= '0;
      op_q  <= OP_ADD;
      x_q   <= '0;
      y_q   <= '0;
      res_q <= '0;
      tag_q <= UNLOCKED;
      tgt_q <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (capture) begin
              pc_q  <= bus.pc_in;
              op_q  <= bus.op_in;
              x_q   <= bus.datax_in;
              y_q   <= bus.datay_in;
              tag_q <= bus.tagw_in;
              tgt_q <= bus.target_in;
              state <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (go_serial) begin
              res_q <= x_q;
              cnt_q <= y_q[4:0];
              state <= S_SHIFT;
            end else begin
              res_q <= core_res;
              state <= S_DONE;
            end
          end
          S_SHIFT: begin
            res_q <= shift_step(op_q, res_q);
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) state <= S_DONE;
          end
          S_DONE: begin
            if (bus.cdb_grant) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy_out       = (state != S_IDLE);
  assign bus.en_out         = (state == S_DONE);
  assign bus.data_out       = res_q;
  assign bus.tag_out        = tag_q;
  assign bus.target_out     = tgt_q;
  assign bus.result_src_out = ALU_ID[0];

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: expected results are queued at issue and popped by a monitor on each granted broadcast.
`timescale 1ns/1ps
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int ALU_ID_P = 0;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;

  alu_exec_if bus ();

  alu_exec #(.ALU_ID(ALU_ID_P), .SHIFT_ITER(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    word_t    data;
    regtag_t  tag;
    regaddr_t target;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A result counts as broadcast only when granted with the unit live (not stalled, flushed or reset).
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rdy && !flush && bus.en_out && bus.cdb_grant) begin
      if (sb_q.size() == 0) begin
        check("unexpected_broadcast", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", bus.data_out, e.data);
        check("sb_tag", {28'b0, bus.tag_out}, {28'b0, e.tag});
        check("sb_target", {27'b0, bus.target_out}, {27'b0, e.target});
      end
    end
  end

  task automatic drive_op(input sinst_t op, input word_t x, input word_t y, input regtag_t tw, input regaddr_t tg);
    bus.busy_in   = 1'b1;
    bus.op_in     = op;
    bus.datax_in  = x;
    bus.datay_in  = y;
    bus.tagw_in   = tw;
    bus.target_in = tg;
    bus.pc_in     = 32'h0000_1000;
    bus.tagx_in   = UNLOCKED;
    bus.tagy_in   = UNLOCKED;
  endtask

  // Issue one instruction, measure capture->en_out latency, optionally withhold grant / stall mid-flight.
  task automatic run_op(input string name, input sinst_t op, input word_t x, input word_t y,
                        input regtag_t tw, input regaddr_t tg, input word_t exp_d,
                        input int exp_lat, input int hold, input int stall_at);
    int   lat;
    exp_t e;
    drive_op(op, x, y, tw, tg);
    e.data = exp_d; e.tag = tw; e.target = tg;
    sb_q.push_back(e);
    tick();
    bus.busy_in = 1'b0;
    lat = 1;
    while (!bus.en_out && lat < 80) begin
      if (lat == stall_at) begin
        rdy = 1'b0;
        repeat (3) begin
          tick();
          lat++;
          check({name, "_stall_en"}, {31'b0, bus.en_out}, 32'd0);
          check({name, "_stall_busy"}, {31'b0, bus.busy_out}, 32'd1);
        end
        rdy = 1'b1;
      end
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    repeat (hold) begin
      check({name, "_hold_en"}, {31'b0, bus.en_out}, 32'd1);
      check({name, "_hold_data"}, bus.data_out, exp_d);
      check({name, "_hold_busy"}, {31'b0, bus.busy_out}, 32'd1);
      tick();
    end
    if (hold > 0) begin
      rdy = 1'b0;
      bus.cdb_grant = 1'b1;
      repeat (2) begin
        tick();
        check({name, "_frozen_done_en"}, {31'b0, bus.en_out}, 32'd1);
      end
      rdy = 1'b1;
    end
    bus.cdb_grant = 1'b1;
    check({name, "_busy_at_grant"}, {31'b0, bus.busy_out}, 32'd1);
    tick();
    bus.cdb_grant = 1'b0;
    check({name, "_busy_free"}, {31'b0, bus.busy_out}, 32'd0);
    check({name, "_en_free"}, {31'b0, bus.en_out}, 32'd0);
  endtask

  // Abandon an in-flight instruction by flush (with grant if in DONE) or by reset.
  task automatic run_kill(input string name, input sinst_t op, input word_t x, input word_t y,
                          input int at_done, input int do_reset);
    int lat;
    drive_op(op, x, y, 4'd6, 5'd9);
    tick();
    bus.busy_in = 1'b0;
    lat = 1;
    if (at_done != 0) begin
      while (!bus.en_out && lat < 80) begin
        tick();
        lat++;
      end
    end else begin
      repeat (3) tick();
    end
    check({name, "_inflight_busy"}, {31'b0, bus.busy_out}, 32'd1);
    if (do_reset != 0) begin
      rst = 1'b1;
    end else begin
      flush = 1'b1;
      bus.cdb_grant = (at_done != 0);
    end
    tick();
    rst = 1'b0;
    flush = 1'b0;
    bus.cdb_grant = 1'b0;
    check({name, "_en"}, {31'b0, bus.en_out}, 32'd0);
    check({name, "_busy"}, {31'b0, bus.busy_out}, 32'd0);
    if (do_reset != 0) begin
      check({name, "_data"}, bus.data_out, 32'd0);
      check({name, "_target"}, {27'b0, bus.target_out}, 32'd0);
      check({name, "_tag"}, {28'b0, bus.tag_out}, {28'b0, UNLOCKED});
    end
    tick();
    check({name, "_stays_idle"}, {31'b0, bus.busy_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    bus.busy_in = 1'b0; bus.pc_in = '0; bus.op_in = OP_ADD;
    bus.tagx_in = UNLOCKED; bus.tagy_in = UNLOCKED; bus.tagw_in = '0;
    bus.datax_in = '0; bus.datay_in = '0; bus.target_in = '0; bus.cdb_grant = 1'b0;
    repeat (2) tick();
    check("rst_busy", {31'b0, bus.busy_out}, 32'd0);
    check("rst_en", {31'b0, bus.en_out}, 32'd0);
    check("rst_data", bus.data_out, 32'd0);
    check("rst_target", {27'b0, bus.target_out}, 32'd0);
    check("rst_tag", {28'b0, bus.tag_out}, {28'b0, UNLOCKED});
    check("rst_src", {31'b0, bus.result_src_out}, ALU_ID_P);
    rst = 1'b0;
    tick();

    run_op("add_wrap", OP_ADD, 32'd7, 32'hFFFF_FFFE, 4'd3, 5'd5, 32'd5, 2, 0, 0);

    // Operand y still locked: slot is busy but nothing may be captured.
    drive_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2, 5'd1);
    bus.tagy_in = 4'd4;
    repeat (5) begin
      tick();
      check("locked_no_capture", {31'b0, bus.busy_out}, 32'd0);
    end
    run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2, 5'd1, 32'd1, 2, 0, 0);

    run_op("slt_pos",   OP_SLT,   32'd1,         32'hFFFF_FFFF, 4'd1, 5'd2,  32'd0,         2, 0, 0);
    run_op("sltu",      OP_SLTU,  32'd1,         32'hFFFF_FFFF, 4'd1, 5'd3,  32'd1,         2, 0, 0);
    run_op("sub",       OP_SUB,   32'd3,         32'd5,         4'd7, 5'd4,  32'hFFFF_FFFE, 2, 0, 0);
    run_op("and",       OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 4'd8, 5'd6,  32'hF000_F000, 2, 0, 0);
    run_op("or",        OP_OR,    32'hF0F0_F0F0, 32'h0F0F_0000, 4'd9, 5'd7,  32'hFFFF_F0F0, 2, 0, 0);
    run_op("lui",       OP_LUI,   32'd0,         32'h1234_5000, 4'd0, 5'd8,  32'h1234_5000, 2, 0, 0);
    run_op("auipc",     OP_AUIPC, 32'd0,         32'h0000_0010, 4'd5, 5'd10, 32'h0000_1010, 2, 0, 0);
    run_op("bad_op",    4'hE,     32'd5,         32'd6,         4'd4, 5'd11, 32'd0,         2, 0, 0);
    run_op("sra4",      OP_SRA,   32'h8000_0000, 32'd4,         4'd1, 5'd12, 32'hF800_0000, 6, 0, 0);
    run_op("sra0",      OP_SRA,   32'h8000_0000, 32'h0000_0020, 4'd2, 5'd13, 32'h8000_0000, 2, 0, 0);
    run_op("sll31",     OP_SLL,   32'd1,         32'd31,        4'd3, 5'd14, 32'h8000_0000, 33, 0, 0);
    run_op("sll_imm",   OP_SLL,   32'd3,         32'h0000_0024, 4'd3, 5'd15, 32'h0000_0030, 6, 0, 0);
    run_op("srl_stall", OP_SRL,   32'hF000_0000, 32'd8,         4'd6, 5'd16, 32'h00F0_0000, 13, 0, 4);
    run_op("xor_hold",  OP_XOR,   32'hFF00_FF00, 32'h0FF0_0FF0, 4'd7, 5'd17, 32'hF0F0_F0F0, 2, 6, 0);

    run_kill("flush_shift", OP_SLL, 32'd1, 32'd20, 0, 0);
    run_kill("flush_done",  OP_ADD, 32'd1, 32'd2,  1, 0);
    run_kill("rst_shift",   OP_SLL, 32'd1, 32'd20, 0, 1);
    run_kill("rst_done",    OP_ADD, 32'd1, 32'd2,  1, 1);

    // Flush in the same cycle as a would-be capture wins.
    drive_op(OP_ADD, 32'd1, 32'd1, 4'd1, 5'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.busy_in = 1'b0;
    check("flush_capture_busy", {31'b0, bus.busy_out}, 32'd0);
    tick();
    check("flush_capture_idle", {31'b0, bus.busy_out}, 32'd0);

    run_op("after_kill", OP_ADD, 32'd10, 32'd20, 4'd2, 5'd18, 32'd30, 2, 0, 0);

    repeat (2) tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
